// File: rtl/muldiv_unit_if.sv
// Request/result bus between the pipeline and the iterative multiply/divide unit.
// The master side is the pipeline, the slave side is muldiv_unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  MdOp;
    logic [31:0] DataIn1;
    logic [31:0] DataIn2;
    logic        MtHi;
    logic        MtLo;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output start, MdOp, DataIn1, DataIn2, MtHi, MtLo, Flush,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  start, MdOp, DataIn1, DataIn2, MtHi, MtLo, Flush,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps on operand magnitudes, then one sign-fix cycle.
module muldiv_unit (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        div_zero_q, div_zero_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] opb_q, opb_d;   // multiplicand or divisor magnitude
    logic [31:0] rem_q, rem_d;   // product high half or partial remainder
    logic [31:0] quo_q, quo_d;   // multiplier shifting out or quotient shifting in
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] product;

    assign signed_op = ~bus.MdOp[0];
    assign a_neg     = signed_op & bus.DataIn1[31];
    assign b_neg     = signed_op & bus.DataIn2[31];
    assign mag_a     = a_neg ? -bus.DataIn1 : bus.DataIn1;
    assign mag_b     = b_neg ? -bus.DataIn2 : bus.DataIn2;

    assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : 33'd0);
    assign div_shift = {rem_q, quo_q[31]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_sub   = div_shift[31:0] - opb_q;
    assign product   = {rem_q, quo_q};

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch below can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        opb_d      = opb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        if (bus.Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d    = RUN;
                        cnt_d      = 6'd0;
                        is_div_d   = bus.MdOp[1];
                        div_zero_d = bus.MdOp[1] & (bus.DataIn2 == 32'd0);
                        neg_res_d  = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        opb_d      = mag_b;
                        rem_d      = 32'd0;
                        quo_d      = mag_a;
                    end else begin
                        if (bus.MtHi) hi_d = bus.DataIn1;
                        if (bus.MtLo) lo_d = bus.DataIn1;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + 6'd1;
                    if (is_div_q) begin
                        rem_d = div_ge ? div_sub : div_shift[31:0];
                        quo_d = {quo_q[30:0], div_ge};
                    end else begin
                        rem_d = mul_sum[32:1];
                        quo_d = {mul_sum[0], quo_q[31:1]};
                    end
                    if (cnt_q == 6'd31) state_d = FIX;
                end
                FIX: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        // A zero divisor leaves the full dividend magnitude in rem_q.
                        lo_d = div_zero_q ? 32'hFFFF_FFFF : (neg_res_q ? -quo_q : quo_q);
                        hi_d = neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? -product : product;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so every flop samples the values from before the edge.
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opb_q      <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            opb_q      <= opb_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign bus.Busy = (state_q != IDLE);
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level arithmetic model compared on
// every falling edge, plus directed vectors with hand-computed HI/LO values.
module tb_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst_n;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, computed with plain arithmetic.
    function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [63:0] sa64, sb64;
        int sa, sb;
        logic [63:0] r;
        case (op)
            OP_MULT: begin
                sa64 = {{32{a[31]}}, a};
                sb64 = {{32{b[31]}}, b};
                r = sa64 * sb64;
            end
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    sa = a;
                    sb = b;
                    r = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    typedef struct packed {
        logic [5:0]  cnt;   // cycles until the result lands; 0 means idle
        logic        done;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] res;
    } mstate_t;

    function automatic mstate_t step(input mstate_t s, input logic rst, input logic start,
                                     input logic flush, input logic mthi, input logic mtlo,
                                     input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        mstate_t n = s;
        n.done = 1'b0;
        if (!rst) begin
            n.cnt = 6'd0;
            n.hi  = 32'd0;
            n.lo  = 32'd0;
        end else if (flush) begin
            n.cnt = 6'd0;
        end else if (s.cnt != 6'd0) begin
            n.cnt = s.cnt - 6'd1;
            if (n.cnt == 6'd0) begin
                {n.hi, n.lo} = s.res;
                n.done = 1'b1;
            end
        end else if (start) begin
            n.res = calc(op, a, b);
            n.cnt = 6'd33;
        end else begin
            if (mthi) n.hi = a;
            if (mtlo) n.lo = a;
        end
        return n;
    endfunction

    mstate_t m;
    logic    model_valid = 1'b0;

    always @(posedge clk) begin
        m <= step(m, rst_n, bus.start, bus.Flush, bus.MtHi, bus.MtLo, bus.MdOp,
                  bus.DataIn1, bus.DataIn2);
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_busy", 32'(bus.Busy), 32'(m.cnt != 6'd0));
            check("model_done", 32'(bus.Done), 32'(m.done));
            check("model_hi", bus.Hi, m.hi);
            check("model_lo", bus.Lo, m.lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents a request in the current cycle (cycle 0) and returns in cycle 1
    // with the operand inputs scrambled.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.MdOp    = op;
        bus.DataIn1 = a;
        bus.DataIn2 = b;
        cyc = 0;
        tick();
        bus.start   = 1'b0;
        bus.DataIn1 = $urandom;
        bus.DataIn2 = $urandom;
        bus.MdOp    = 2'($urandom);
    endtask

    task automatic finish_op(input string name);
        while (cyc < 33) tick();
        check({name, "_busy_c33"}, 32'(bus.Busy), 32'd1);
        check({name, "_done_c33"}, 32'(bus.Done), 32'd0);
        tick();
        check({name, "_done_c34"}, 32'(bus.Done), 32'd1);
        check({name, "_busy_c34"}, 32'(bus.Busy), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        start_op(op, a, b);
        finish_op(name);
        check({name, "_hi"}, bus.Hi, ehi);
        check({name, "_lo"}, bus.Lo, elo);
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.Done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.MdOp    = 2'b00;
        bus.DataIn1 = 32'd0;
        bus.DataIn2 = 32'd0;
        bus.MtHi    = 1'b0;
        bus.MtLo    = 1'b0;
        bus.Flush   = 1'b0;
        rst_n       = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_hi", bus.Hi, 32'd0);
        check("rst_lo", bus.Lo, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_7xm3",  OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero",  OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_100_m7", OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
        run_op("div_zero_s", OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu_3",     OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555);
        run_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // HI/LO moves in IDLE
        bus.MtHi    = 1'b1;
        bus.DataIn1 = 32'h1234_5678;
        tick();
        bus.MtHi = 1'b0;
        check("mthi_hi", bus.Hi, 32'h1234_5678);
        check("mthi_lo", bus.Lo, 32'h0000_0000);
        bus.MtHi    = 1'b1;
        bus.MtLo    = 1'b1;
        bus.DataIn1 = 32'hA5A5_A5A5;
        tick();
        bus.MtHi = 1'b0;
        bus.MtLo = 1'b0;
        check("mtboth_hi", bus.Hi, 32'hA5A5_A5A5);
        check("mtboth_lo", bus.Lo, 32'hA5A5_A5A5);

        // Flush outranks start and the moves
        bus.Flush   = 1'b1;
        bus.start   = 1'b1;
        bus.MtHi    = 1'b1;
        bus.MtLo    = 1'b1;
        bus.DataIn1 = 32'd0;
        tick();
        bus.Flush = 1'b0;
        bus.start = 1'b0;
        bus.MtHi  = 1'b0;
        bus.MtLo  = 1'b0;
        check("flushprio_busy", 32'(bus.Busy), 32'd0);
        check("flushprio_hi", bus.Hi, 32'hA5A5_A5A5);
        check("flushprio_lo", bus.Lo, 32'hA5A5_A5A5);

        // start wins over MtHi in the same cycle; moves while busy are ignored
        bus.MtHi = 1'b1;
        start_op(OP_MULTU, 32'h0000_0003, 32'h0000_0004);
        bus.MtHi = 1'b0;
        check("startmt_busy", 32'(bus.Busy), 32'd1);
        check("startmt_hi", bus.Hi, 32'hA5A5_A5A5);
        while (cyc < 5) tick();
        bus.MtHi    = 1'b1;
        bus.MtLo    = 1'b1;
        bus.DataIn1 = 32'h1234_5678;
        tick();
        bus.MtHi = 1'b0;
        bus.MtLo = 1'b0;
        check("busymt_hi", bus.Hi, 32'hA5A5_A5A5);
        check("busymt_lo", bus.Lo, 32'hA5A5_A5A5);
        finish_op("multu_3x4");
        check("multu_3x4_hi", bus.Hi, 32'h0000_0000);
        check("multu_3x4_lo", bus.Lo, 32'h0000_000C);

        // Flush during RUN
        start_op(OP_DIVU, 32'h0000_0064, 32'h0000_0003);
        while (cyc < 10) tick();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("flush_busy_c11", 32'(bus.Busy), 32'd0);
        check("flush_hi", bus.Hi, 32'h0000_0000);
        check("flush_lo", bus.Lo, 32'h0000_000C);
        expect_no_done("flush_no_done", 40);
        check("flush_hi_late", bus.Hi, 32'h0000_0000);

        // Reset during RUN
        bus.MtHi    = 1'b1;
        bus.DataIn1 = 32'hDEAD_BEEF;
        tick();
        bus.MtHi = 1'b0;
        check("mthi2_hi", bus.Hi, 32'hDEAD_BEEF);
        start_op(OP_MULT, 32'h0000_0005, 32'h0000_0006);
        while (cyc < 20) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        check("midrst_hi", bus.Hi, 32'h0000_0000);
        check("midrst_lo", bus.Lo, 32'h0000_0000);
        expect_no_done("midrst_no_done", 40);

        // Back-to-back: new start in the Done cycle
        start_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        finish_op("b2b_a");
        check("b2b_a_hi", bus.Hi, 32'h0000_0001);
        check("b2b_a_lo", bus.Lo, 32'h0000_0000);
        start_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
        check("b2b_busy_c1", 32'(bus.Busy), 32'd1);
        finish_op("b2b_b");
        check("b2b_b_hi", bus.Hi, 32'h0000_000F);
        check("b2b_b_lo", bus.Lo, 32'h0FFF_FFFF);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
